nested_loop_addr_gen: RTL and testbench
=======================================

NESTED_LOOP_ADDR_GEN -- requirements
Module: nested_loop_addr_gen

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- LOOP_ID_W, 5, loop-id width; MAX_LOOPS = 2**LOOP_ID_W.
- LOOP_ITER_W, 16, iteration-count width.
- ADDR_WIDTH, 8, address width.
- ADDR_STRIDE_W, ADDR_WIDTH, stride width.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock. The block SHALL have one clock; reset is asynchronous and active-high.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, launch the walk.
- stall, in, 1, hold the current step.
- base_addr, in, ADDR_WIDTH, start address; sampled on start.
- cfg_loop_iter_v, in, 1, write enable for an iteration count.
- cfg_loop_iter, in, LOOP_ITER_W, iterations minus 1.
- cfg_loop_iter_loop_id, in, LOOP_ID_W, target loop; 0 = outermost.
- cfg_addr_stride_v, in, 1, write enable for a stride.
- cfg_addr_stride, in, ADDR_STRIDE_W, stride value.
- done, out, 1, completion pulse.
- loop_init, out, 1, first-step pulse.
- loop_index, out, LOOP_ID_W, loop advanced this step.
- loop_index_valid, out, 1, a step is presented.
- loop_last_iter, out, 1, innermost loop is on its final iteration.
- loop_exit, out, 1, step wrapped the innermost loop.
- addr_out, out, ADDR_WIDTH, generated address.
- addr_out_valid, out, 1, addr_out is valid.

Function
REQ-003 Configuration:
- cfg_loop_iter_v writes iter[cfg_loop_iter_loop_id].
- num_loops = last written id + 1.
- cfg_addr_stride_v writes stride[sptr], then sptr increments; sptr clears on start.
- Configuration SHALL occur only while in IDLE.

REQ-004 States SHALL be IDLE, RUN, DONE. Transitions:
- IDLE -> RUN on start with num_loops > 0.
- IDLE -> DONE on start with num_loops == 0.
- RUN -> DONE after the final step is consumed.
- DONE -> IDLE unconditionally after one cycle.

REQ-005 On entering RUN, all counters SHALL be 0, and loop_init SHALL be high for exactly the first RUN cycle.

REQ-006 loop_index_valid SHALL be 1 in every RUN cycle. A step is consumed when loop_index_valid & ~stall.

REQ-007 Step 0 SHALL present loop_index = num_loops-1 and advance no counter.

REQ-008 Every later step SHALL advance loop k, the innermost loop whose counter < iter[k]:
- counter[k] increments;
- all counters j > k clear;
- loop_index = k.

REQ-009 loop_exit SHALL be 1 on a step where k < num_loops-1.

REQ-010 loop_last_iter SHALL equal (counter[num_loops-1] == iter[num_loops-1]) in RUN.

REQ-011 Total steps SHALL equal the product of (iter[i]+1). After the last step is consumed, RUN -> DONE.

REQ-012 Walker: maintain addr_reg[0..MAX_LOOPS-1].
- On step 0, all entries load base_addr and addr_out = base_addr.
- On step at k, A = addr_reg[k] + stride[k] modulo 2**ADDR_WIDTH; addr_reg[j] = A for all j >= k; addr_out = A.
- Strides SHALL be treated as unsigned.

REQ-013 addr_out and addr_out_valid SHALL be registered, one cycle after the consumed step. addr_out_valid SHALL be 0 otherwise.

REQ-014 done SHALL be a 1-cycle pulse in the DONE state, i.e. the same cycle as the last addr_out_valid.

REQ-015 While stall is high, counters, addr_reg and outputs other than addr_out_valid SHALL hold, and addr_out_valid SHALL be 0.

REQ-016 start SHALL be ignored outside IDLE. loop_init and loop_index_valid SHALL be 0 outside RUN.

Reset
REQ-017 Asynchronous reset SHALL clear:
- the state to IDLE;
- all counters, addr_reg, sptr and num_loops;
- iter[] and stride[] to 0;
- every output to 0.

REQ-018 Reset asserted mid-RUN SHALL abort immediately, with no done pulse. After release the block SHALL require reconfiguration.

Structure
REQ-019 The state encoding (IDLE/RUN/DONE) and the default widths SHALL live in a shared package.

REQ-020 The block SHALL contain one sub-module, loop_addr_walker, implementing REQ-012/013. The loop counting (REQ-004..011) SHALL remain in the top.

Verification
REQ-021 Base and 2D walk:
- Stimulus: base=0x10; iter[0]=1, iter[1]=2; strides 8 then 1; start.
- Required: addr_out 0x10, 0x11, 0x12, 0x18, 0x19, 0x1A on consecutive cycles; done with the last address; loop_exit on the 4th step only.

REQ-022 Stall:
- Stimulus: same setup, stall high for 3 cycles after the 2nd address.
- Required: identical address sequence, delayed 3 cycles, with no duplicated addr_out_valid.

REQ-023 Single loop:
- Stimulus: iter[0]=0, base=0x55.
- Required: one address 0x55; loop_init and done exactly one cycle apart.

REQ-024 Empty start:
- Stimulus: start with no loops configured.
- Required: done pulse the next cycle; no addr_out_valid.

REQ-025 Wrap-around:
- Stimulus: base=0xFE, iter[0]=3, stride=1.
- Required: 0xFE, 0xFF, 0x00, 0x01.

REQ-026 Reset mid-run:
- Stimulus: assert reset during the 3rd step.
- Required: all outputs 0 immediately (asynchronous); no done; state IDLE.

Source files
------------

// File: rtl/nested_loop_addr_gen_pkg.sv
// Shared state encoding and default widths for the nested loop address generator.
package nested_loop_addr_gen_pkg;

  localparam int unsigned DEF_LOOP_ID_W   = 5;
  localparam int unsigned DEF_LOOP_ITER_W = 16;
  localparam int unsigned DEF_ADDR_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nested_loop_addr_gen_walker.sv
// Address walker: one running address per loop level, updated on each consumed step.
module loop_addr_walker
  import nested_loop_addr_gen_pkg::*;
#(
  parameter int unsigned LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned ADDR_STRIDE_W = ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_valid,
  input  logic                     step_first,
  input  logic [LOOP_ID_W-1:0]     step_loop,
  input  logic [ADDR_STRIDE_W-1:0] step_stride,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_out_valid
);

  localparam int unsigned MAX_LOOPS = 2 ** LOOP_ID_W;

  logic [ADDR_WIDTH-1:0] addr_reg [MAX_LOOPS];
  logic [ADDR_WIDTH-1:0] next_addr;

  // Unsigned stride add wraps modulo the address width.
  always_comb begin
    next_addr = base_addr;
    if (!step_first) begin
      next_addr = ADDR_WIDTH'(addr_reg[step_loop] + ADDR_WIDTH'(step_stride));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_out       <= '0;
      addr_out_valid <= 1'b0;
      for (int j = 0; j < MAX_LOOPS; j++) begin
        addr_reg[j] <= '0;
      end
    end else begin
      addr_out_valid <= step_valid;
      if (step_valid) begin
        addr_out <= next_addr;
        for (int j = 0; j < MAX_LOOPS; j++) begin
          if (step_first || (LOOP_ID_W'(j) >= step_loop)) begin
            addr_reg[j] <= next_addr;
          end
        end
      end
    end
  end

endmodule

// File: rtl/nested_loop_addr_gen.sv
// Nested loop counter with per-level strides; walks every iteration tuple and emits addresses.
module nested_loop_addr_gen
  import nested_loop_addr_gen_pkg::*;
#(
  parameter int unsigned LOOP_ID_W     = DEF_LOOP_ID_W,
  parameter int unsigned LOOP_ITER_W   = DEF_LOOP_ITER_W,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned ADDR_STRIDE_W = ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
  input  logic [LOOP_ID_W-1:0]     cfg_loop_iter_loop_id,
  input  logic                     cfg_addr_stride_v,
  input  logic [ADDR_STRIDE_W-1:0] cfg_addr_stride,
  output logic                     done,
  output logic                     loop_init,
  output logic [LOOP_ID_W-1:0]     loop_index,
  output logic                     loop_index_valid,
  output logic                     loop_last_iter,
  output logic                     loop_exit,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_out_valid
);

  localparam int unsigned MAX_LOOPS = 2 ** LOOP_ID_W;
  localparam int unsigned NUM_W     = LOOP_ID_W + 1;

  state_e                   state;
  logic [LOOP_ITER_W-1:0]   iter    [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0]   cnt     [MAX_LOOPS];
  logic [LOOP_ITER_W-1:0]   cnt_adv [MAX_LOOPS];
  logic [ADDR_STRIDE_W-1:0] stride  [MAX_LOOPS];
  logic [NUM_W-1:0]         num_loops;
  logic [LOOP_ID_W-1:0]     sptr;
  logic [LOOP_ID_W-1:0]     last_id;
  logic [LOOP_ID_W-1:0]     k_next;
  logic [ADDR_WIDTH-1:0]    base_reg;
  logic                     consume;
  logic                     all_max;

  assign last_id = LOOP_ID_W'(num_loops - NUM_W'(1));
  assign consume = loop_index_valid & ~stall;

  // Counters after consuming the presented step, whether that was the final tuple,
  // and which loop the following step would advance (innermost with room left).
  always_comb begin
    all_max = 1'b1;
    k_next  = '0;
    for (int i = 0; i < MAX_LOOPS; i++) begin
      cnt_adv[i] = cnt[i];
      if (!loop_init) begin
        if (LOOP_ID_W'(i) == loop_index) begin
          cnt_adv[i] = cnt[i] + LOOP_ITER_W'(1);
        end else if (LOOP_ID_W'(i) > loop_index) begin
          cnt_adv[i] = '0;
        end
      end
      if (NUM_W'(i) < num_loops) begin
        if (cnt_adv[i] != iter[i]) all_max = 1'b0;
        if (cnt_adv[i] < iter[i])  k_next  = LOOP_ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      num_loops        <= '0;
      sptr             <= '0;
      base_reg         <= '0;
      done             <= 1'b0;
      loop_init        <= 1'b0;
      loop_index       <= '0;
      loop_index_valid <= 1'b0;
      loop_last_iter   <= 1'b0;
      loop_exit        <= 1'b0;
      for (int i = 0; i < MAX_LOOPS; i++) begin
        iter[i]   <= '0;
        stride[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_loop_iter_v) begin
            iter[cfg_loop_iter_loop_id] <= cfg_loop_iter;
            num_loops <= NUM_W'(cfg_loop_iter_loop_id) + NUM_W'(1);
          end
          if (cfg_addr_stride_v) begin
            stride[sptr] <= cfg_addr_stride;
            sptr         <= sptr + LOOP_ID_W'(1);
          end
          if (start) begin
            sptr     <= '0;
            base_reg <= base_addr;
            for (int i = 0; i < MAX_LOOPS; i++) begin
              cnt[i] <= '0;
            end
            if (num_loops != '0) begin
              state            <= ST_RUN;
              loop_init        <= 1'b1;
              loop_index_valid <= 1'b1;
              loop_index       <= last_id;
              loop_exit        <= 1'b0;
              loop_last_iter   <= (iter[last_id] == '0);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (consume) begin
            loop_init <= 1'b0;
            for (int i = 0; i < MAX_LOOPS; i++) begin
              cnt[i] <= cnt_adv[i];
            end
            if (all_max) begin
              state            <= ST_DONE;
              done             <= 1'b1;
              loop_index_valid <= 1'b0;
              loop_index       <= '0;
              loop_exit        <= 1'b0;
              loop_last_iter   <= 1'b0;
            end else begin
              loop_index     <= k_next;
              loop_exit      <= (k_next != last_id);
              loop_last_iter <= (cnt_adv[last_id] == iter[last_id]);
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  loop_addr_walker #(
    .LOOP_ID_W     (LOOP_ID_W),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .ADDR_STRIDE_W (ADDR_STRIDE_W)
  ) u_walker (
    .clk            (clk),
    .reset          (reset),
    .step_valid     (consume),
    .step_first     (loop_init),
    .step_loop      (loop_index),
    .step_stride    (stride[loop_index]),
    .base_addr      (base_reg),
    .addr_out       (addr_out),
    .addr_out_valid (addr_out_valid)
  );

endmodule

// File: tb/tb_nested_loop_addr_gen.sv
// Directed bench: tuple-enumeration model of the walk plus hand-computed pins.
module tb_nested_loop_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        cfg_loop_iter_v = 1'b0;
  logic [15:0] cfg_loop_iter = '0;
  logic [4:0]  cfg_loop_iter_loop_id = '0;
  logic        cfg_addr_stride_v = 1'b0;
  logic [7:0]  cfg_addr_stride = '0;
  logic        done, loop_init, loop_index_valid, loop_last_iter, loop_exit, addr_out_valid;
  logic [4:0]  loop_index;
  logic [7:0]  addr_out;

  nested_loop_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .base_addr(base_addr),
    .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
    .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id),
    .cfg_addr_stride_v(cfg_addr_stride_v), .cfg_addr_stride(cfg_addr_stride),
    .done(done), .loop_init(loop_init), .loop_index(loop_index),
    .loop_index_valid(loop_index_valid), .loop_last_iter(loop_last_iter),
    .loop_exit(loop_exit), .addr_out(addr_out), .addr_out_valid(addr_out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int idx;
    bit ex;
    bit init;
    bit last;
  } step_t;

  step_t exp_step[$];
  int    exp_addr[$];
  int    cap_addr[$];
  int    cap_cyc[$];
  int    cap_exit[$];
  int    m_iter[4];
  int    m_stride[4];

  // Digit i of step s in the mixed-radix iteration tuple (loop 0 most significant).
  function automatic int digit(input int s, input int i, input int n);
    int div = 1;
    for (int j = i + 1; j < n; j++) div *= m_iter[j] + 1;
    return (s / div) % (m_iter[i] + 1);
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [18:0] outs();
    return {done, loop_init, loop_index_valid, loop_last_iter, loop_exit,
            loop_index, addr_out_valid, addr_out};
  endfunction

  // Address of a tuple is base + sum(c_i * stride_i); the advanced loop is the outermost changed digit.
  task automatic build_model(input int b, input int n);
    int total;
    exp_step.delete(); exp_addr.delete();
    cap_addr.delete(); cap_cyc.delete(); cap_exit.delete();
    total = (n == 0) ? 0 : 1;
    for (int i = 0; i < n; i++) total *= m_iter[i] + 1;
    for (int s = 0; s < total; s++) begin
      step_t e;
      int a = b;
      for (int i = 0; i < n; i++) a += digit(s, i, n) * m_stride[i];
      exp_addr.push_back(a & 255);
      if (s == 0) begin
        e.idx = n - 1; e.ex = 1'b0; e.init = 1'b1;
        e.last = (m_iter[n-1] == 0);
      end else begin
        e.idx = n - 1;
        for (int i = n - 1; i >= 0; i--) if (digit(s, i, n) != digit(s - 1, i, n)) e.idx = i;
        e.ex = (e.idx < n - 1); e.init = 1'b0;
        e.last = (digit(s - 1, n - 1, n) == m_iter[n-1]);
      end
      exp_step.push_back(e);
    end
  endtask

  bit    mon_en = 1'b0;
  bit    done_seen = 1'b0;
  bit    stall_d = 1'b0;
  int    done_count = 0;
  int    done_cyc = -1;
  int    init_cyc = -1;
  int    start_cyc = 0;
  step_t s_pop;
  int    a_pop;

  always @(negedge clk) begin
    if (done) begin
      done_count++; done_seen = 1'b1; done_cyc = cyc;
    end
    if (mon_en) begin
      if (loop_init && init_cyc < 0) init_cyc = cyc;
      if (loop_index_valid && !stall) begin
        if (exp_step.size() == 0) chk("extra_step", 1, 0);
        else begin
          s_pop = exp_step.pop_front();
          chk("step_index", loop_index, s_pop.idx);
          chk("step_exit", loop_exit, s_pop.ex);
          chk("step_init", loop_init, s_pop.init);
          chk("step_last_iter", loop_last_iter, s_pop.last);
          cap_exit.push_back(int'(loop_exit));
        end
      end
      if (stall_d) chk("valid_after_stall", addr_out_valid, 0);
      if (addr_out_valid) begin
        cap_addr.push_back(int'(addr_out)); cap_cyc.push_back(cyc);
        if (exp_addr.size() == 0) chk("extra_addr", 1, 0);
        else begin
          a_pop = exp_addr.pop_front();
          chk("addr", addr_out, a_pop);
          chk("done_with_last", done, exp_addr.size() == 0);
        end
      end else if (done) begin
        chk("done_early", exp_addr.size(), 0);
      end
    end
    stall_d = stall && loop_index_valid;
  end

  // Tasks start and end just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    #1 chk("reset_outputs", outs(), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cfg_iter(input int id, input int val);
    cfg_loop_iter_v = 1'b1; cfg_loop_iter_loop_id = 5'(id); cfg_loop_iter = 16'(val);
    m_iter[id] = val;
    @(posedge clk); #1;
    cfg_loop_iter_v = 1'b0;
  endtask

  task automatic cfg_stride(input int idx, input int val);
    cfg_addr_stride_v = 1'b1; cfg_addr_stride = 8'(val);
    m_stride[idx] = val;
    @(posedge clk); #1;
    cfg_addr_stride_v = 1'b0;
  endtask

  task automatic run_walk(input int b, input int sf, input int sl, input int budget);
    done_seen = 1'b0; done_count = 0; init_cyc = -1; done_cyc = -1; mon_en = 1'b1;
    base_addr = 8'(b); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'hAA;
    for (int r = 0; r < budget && !done_seen; r++) begin
      stall = (r >= sf) && (r < sf + sl);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    if (!done_seen) chk("walk_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("steps_left", exp_step.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    chk("done_pulses", done_count, 1);
    mon_en = 1'b0;
  endtask

  int exp1[6] = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A};
  int exit1[6] = '{0, 0, 0, 1, 0, 0};
  int expw[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    #1 do_reset();

    // 2D walk
    cfg_iter(0, 1); cfg_iter(1, 2); cfg_stride(0, 8'h08); cfg_stride(1, 8'h01);
    build_model(8'h10, 2);
    run_walk(8'h10, 1000, 0, 50);
    chk("t1_count", cap_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_addr_pin", at(cap_addr, i), exp1[i]);
    for (int i = 0; i < 6; i++) chk("t1_exit_pin", at(cap_exit, i), exit1[i]);
    chk("t1_first_cyc", at(cap_cyc, 0), start_cyc + 2);
    chk("t1_done_cyc", done_cyc, start_cyc + 7);

    // Same walk with a 3-cycle stall; configuration is retained
    build_model(8'h10, 2);
    run_walk(8'h10, 2, 3, 50);
    chk("t2_count", cap_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_addr_pin", at(cap_addr, i), exp1[i]);
    chk("t2_gap", at(cap_cyc, 2) - at(cap_cyc, 1), 4);
    chk("t2_span", at(cap_cyc, 5) - at(cap_cyc, 0), 8);

    // Single loop, single iteration
    do_reset();
    cfg_iter(0, 0); cfg_stride(0, 8'h33);
    build_model(8'h55, 1);
    run_walk(8'h55, 1000, 0, 20);
    chk("t3_count", cap_addr.size(), 1);
    chk("t3_addr_pin", at(cap_addr, 0), 8'h55);
    chk("t3_init_to_done", done_cyc - init_cyc, 1);

    // Empty start
    do_reset();
    build_model(8'h42, 0);
    run_walk(8'h42, 1000, 0, 20);
    chk("t4_count", cap_addr.size(), 0);
    chk("t4_done_cyc", done_cyc, start_cyc + 1);

    // Address wrap-around
    do_reset();
    cfg_iter(0, 3); cfg_stride(0, 8'h01);
    build_model(8'hFE, 1);
    run_walk(8'hFE, 1000, 0, 20);
    for (int i = 0; i < 4; i++) chk("t5_addr_pin", at(cap_addr, i), expw[i]);

    // 3D walk with a stall mid-way
    do_reset();
    cfg_iter(0, 1); cfg_iter(1, 1); cfg_iter(2, 2);
    cfg_stride(0, 8'h40); cfg_stride(1, 8'h05); cfg_stride(2, 8'h03);
    build_model(8'h20, 3);
    run_walk(8'h20, 4, 2, 60);
    chk("t6_count", cap_addr.size(), 12);
    chk("t6_last_pin", at(cap_addr, 11), 8'h6B);

    // Reset during the third step
    do_reset();
    cfg_iter(0, 1); cfg_iter(1, 2); cfg_stride(0, 8'h08); cfg_stride(1, 8'h01);
    done_count = 0;
    base_addr = 8'h10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t7_running", loop_index_valid, 1);
    #2 reset = 1'b1;
    #1 chk("t7_async_clear", outs(), 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t7_no_done", done_count, 0);
    build_model(8'h10, 0);
    run_walk(8'h10, 1000, 0, 20);
    chk("t7_cfg_cleared", cap_addr.size(), 0);
    chk("t7_done_cyc", done_cyc, start_cyc + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
